alu_stage: RTL and testbench

Operand staging, sequencing and status-flag stage wrapped around the combinational 6502 ALU. Accepts one ALU operation per handshake from the control unit and drives the ALU inputs from registered operands. Captures the ALU result, carry and overflow, applies optional BCD correction, and updates the processor status register P. It sits directly between instruction decode/execute control and the ALU, and owns the architectural P register.

---
 rtl/alu_stage_pkg.sv | 39 +++
 rtl/alu_stage_bcd_adjust.sv | 39 +++
 rtl/alu_stage.sv | 208 ++++++++++++++++++++
 tb/tb_alu_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
// Shared definitions for alu_stage: ALU control codes, P register bit indices,
// flag-mask positions and FSM state encoding.
package alu_stage_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SR  = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam logic [7:0] P_RESET = 8'h24;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // Positions inside op_flag_mask {N,Z,C,V}
  localparam int M_V = 0;
  localparam int M_C = 1;
  localparam int M_Z = 2;
  localparam int M_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DADJ = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic half_carry(input logic [3:0] a, input logic [3:0] b, input logic cin);
    return ({1'b0, a} + {1'b0, b} + {4'b0000, cin}) > 5'd15;
  endfunction

endpackage

// File: rtl/alu_stage_bcd_adjust.sv
// Combinational decimal correction of a binary ADC/SBC result using the
// binary carry and the low-nibble half-carry.
module bcd_adjust
  import alu_stage_pkg::*;
(
  input  logic [7:0] bin_sum,
  input  logic       carry_in,
  input  logic       half_carry,
  input  logic       sub,
  output logic [7:0] adj_sum,
  output logic       carry_out
);

  logic       lo_fix_s;
  logic       hi_fix_s;
  logic [8:0] lo_adj_s;

  // Nibble corrections; for add the high check sees the low-corrected value
  always_comb begin
    lo_fix_s  = 1'b0;
    hi_fix_s  = 1'b0;
    lo_adj_s  = {1'b0, bin_sum};
    adj_sum   = bin_sum;
    carry_out = carry_in;
    if (sub) begin
      lo_fix_s  = ~half_carry;
      hi_fix_s  = ~carry_in;
      adj_sum   = bin_sum - (lo_fix_s ? 8'h06 : 8'h00) - (hi_fix_s ? 8'h60 : 8'h00);
      carry_out = carry_in;
    end else begin
      lo_fix_s  = half_carry || (bin_sum[3:0] > 4'd9);
      lo_adj_s  = {1'b0, bin_sum} + (lo_fix_s ? 9'h006 : 9'h000);
      hi_fix_s  = carry_in || lo_adj_s[8] || (lo_adj_s[7:4] > 4'd9);
      adj_sum   = lo_adj_s[7:0] + (hi_fix_s ? 8'h60 : 8'h00);
      carry_out = hi_fix_s;
    end
  end

endmodule

// File: rtl/alu_stage.sv
// Operand staging, sequencing and P-flag update around the 6502 ALU.
// Decimal (BCD) correction is built only when ALU_STAGE_DECIMAL_EN is defined.
module alu_stage
  import alu_stage_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       op_sub,
  input  logic       op_use_carry,
  input  logic       op_cin,
  input  logic       op_cmp,
  input  logic [3:0] op_flag_mask,
  output logic [2:0] alu_control,
  output logic [7:0] alu_AI,
  output logic [7:0] alu_BI,
  output logic       alu_carry_in,
  input  logic [7:0] alu_Y,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic [7:0] p_reg,
  input  logic       p_load,
  input  logic [7:0] p_din
);

  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] a_q, a_d;
  logic [7:0] bi_q, bi_d;
  logic       cin_q, cin_d;
  logic       cmp_q, cmp_d;
  logic [3:0] mask_q, mask_d;
  logic [7:0] bin_q, bin_d;
  logic [7:0] fin_q, fin_d;
  logic       cfin_q, cfin_d;
  logic       ovf_q, ovf_d;
  logic       op_ready_q, op_ready_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
  logic [7:0] p_q, p_d;

`ifdef ALU_STAGE_DECIMAL_EN
  logic       sub_q, sub_d;
  logic       hc_q, hc_d;
  logic [7:0] adj_s;
  logic       adj_c_s;

  bcd_adjust u_bcd_adjust (
    .bin_sum    (bin_q),
    .carry_in   (cfin_q),
    .half_carry (hc_q),
    .sub        (sub_q),
    .adj_sum    (adj_s),
    .carry_out  (adj_c_s)
  );
`endif

  // Next-state, operand staging and result capture
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    a_d        = a_q;
    bi_d       = bi_q;
    cin_d      = cin_q;
    cmp_d      = cmp_q;
    mask_d     = mask_q;
    bin_d      = bin_q;
    fin_d      = fin_q;
    cfin_d     = cfin_q;
    ovf_d      = ovf_q;
    res_data_d = res_data_q;
`ifdef ALU_STAGE_DECIMAL_EN
    sub_d      = sub_q;
    hc_d       = hc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          code_d  = op_code;
          a_d     = op_a;
          bi_d    = op_sub ? ~op_b : op_b;
          cin_d   = op_use_carry ? p_q[P_C] : op_cin;
          cmp_d   = op_cmp;
          mask_d  = op_flag_mask;
`ifdef ALU_STAGE_DECIMAL_EN
          sub_d   = op_sub;
`endif
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        bin_d  = alu_Y;
        fin_d  = alu_Y;
        cfin_d = alu_carry_out;
        ovf_d  = alu_overflow;
`ifdef ALU_STAGE_DECIMAL_EN
        hc_d   = half_carry(a_q[3:0], bi_q[3:0], cin_q);
        if (p_q[P_D] && (code_q == ALU_ADD) && !cmp_q) begin
          state_d = ST_DADJ;
        end else begin
          state_d = ST_DONE;
        end
`else
        state_d = ST_DONE;
`endif
      end
`ifdef ALU_STAGE_DECIMAL_EN
      ST_DADJ: begin
        fin_d   = adj_s;
        cfin_d  = adj_c_s;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (!cmp_q) begin
          res_data_d = fin_q;
        end else begin
          res_data_d = res_data_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    op_ready_d  = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
  end

  // Status register: an explicit load beats (and discards) the DONE flag update
  always_comb begin
    p_d = p_q;
    if (p_load) begin
      p_d      = p_din;
      p_d[P_U] = 1'b1;
    end else if (state_q == ST_DONE) begin
      p_d[P_N] = mask_q[M_N] ? bin_q[7]          : p_q[P_N];
      p_d[P_Z] = mask_q[M_Z] ? (bin_q == 8'h00)  : p_q[P_Z];
      p_d[P_C] = mask_q[M_C] ? cfin_q            : p_q[P_C];
      p_d[P_V] = mask_q[M_V] ? ovf_q             : p_q[P_V];
    end else begin
      p_d = p_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      code_q      <= ALU_ADD;
      a_q         <= 8'h00;
      bi_q        <= 8'h00;
      cin_q       <= 1'b0;
      cmp_q       <= 1'b0;
      mask_q      <= 4'h0;
      bin_q       <= 8'h00;
      fin_q       <= 8'h00;
      cfin_q      <= 1'b0;
      ovf_q       <= 1'b0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      p_q         <= P_RESET;
`ifdef ALU_STAGE_DECIMAL_EN
      sub_q       <= 1'b0;
      hc_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      a_q         <= a_d;
      bi_q        <= bi_d;
      cin_q       <= cin_d;
      cmp_q       <= cmp_d;
      mask_q      <= mask_d;
      bin_q       <= bin_d;
      fin_q       <= fin_d;
      cfin_q      <= cfin_d;
      ovf_q       <= ovf_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      p_q         <= p_d;
`ifdef ALU_STAGE_DECIMAL_EN
      sub_q       <= sub_d;
      hc_q        <= hc_d;
`endif
    end
  end

  assign op_ready     = op_ready_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign p_reg        = p_q;
  assign alu_control  = code_q;
  assign alu_AI       = a_q;
  assign alu_BI       = bi_q;
  assign alu_carry_in = cin_q;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: behavioural ALU drives the DUT, a
// reference model tracks expected res_data / P from the operation semantics.
module tb_alu_stage;

  logic       clk = 1'b0;
  logic       resetn;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_a, op_b;
  logic       op_sub, op_use_carry, op_cin, op_cmp;
  logic [3:0] op_flag_mask;
  logic [2:0] alu_control;
  logic [7:0] alu_AI, alu_BI;
  logic       alu_carry_in;
  logic [7:0] alu_Y;
  logic       alu_carry_out, alu_overflow;
  logic       res_valid;
  logic [7:0] res_data;
  logic [7:0] p_reg;
  logic       p_load;
  logic [7:0] p_din;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_p;
  logic [7:0] exp_res;

  alu_stage dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .op_use_carry(op_use_carry), .op_cin(op_cin), .op_cmp(op_cmp),
    .op_flag_mask(op_flag_mask), .alu_control(alu_control), .alu_AI(alu_AI),
    .alu_BI(alu_BI), .alu_carry_in(alu_carry_in), .alu_Y(alu_Y),
    .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_data(res_data), .p_reg(p_reg),
    .p_load(p_load), .p_din(p_din)
  );

  always #5 clk = ~clk;

  // Behavioural 6502 ALU
  logic [8:0] s9;
  always_comb begin
    s9 = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_carry_in};
    alu_Y = 8'h00; alu_carry_out = 1'b0; alu_overflow = 1'b0;
    case (alu_control)
      3'b000: begin
        alu_Y = s9[7:0]; alu_carry_out = s9[8];
        alu_overflow = (alu_AI[7] == alu_BI[7]) && (s9[7] != alu_AI[7]);
      end
      3'b001: begin alu_Y = {alu_carry_in, alu_AI[7:1]}; alu_carry_out = alu_AI[0]; end
      3'b010: alu_Y = alu_AI & alu_BI;
      3'b011: alu_Y = alu_AI | alu_BI;
      3'b100: alu_Y = alu_AI ^ alu_BI;
      default: alu_Y = 8'h00;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, binary result (for N/Z), carry, overflow
  task automatic model(input int code, input int a, input int b, input int sub, input int cin,
                       input bit dec, output logic [7:0] res, output logic [7:0] bin,
                       output logic c, output logic v);
    int bo, sum, sa, sb, lo, hi;
    bo = sub ? 255 - b : b;
    c = 1'b0; v = 1'b0; bin = 8'h00;
    case (code)
      0: begin
        sum = a + bo + cin;
        bin = 8'(sum);
        c   = (sum > 255);
        sa  = (a  > 127) ? a  - 256 : a;
        sb  = (bo > 127) ? bo - 256 : bo;
        v   = (sa + sb + cin > 127) || (sa + sb + cin < -128);
      end
      1: begin bin = 8'((a / 2) + cin * 128); c = (a % 2 == 1); end
      2: bin = 8'(a & b);
      3: bin = 8'(a | b);
      4: bin = 8'(a ^ b);
      default: bin = 8'h00;
    endcase
    res = bin;
    if (dec) begin
      if (sub == 0) begin
        lo = (a % 16) + (b % 16) + cin;
        if (lo > 9) lo += 6;
        hi = (a / 16) + (b / 16) + ((lo > 15) ? 1 : 0);
        if (hi > 9) hi += 6;
        c = (hi > 15);
      end else begin
        lo = (a % 16) - (b % 16) - (1 - cin);
        hi = (a / 16) - (b / 16);
        if (lo < 0) begin lo -= 6; hi -= 1; end
        if (hi < 0) hi -= 6;
      end
      res = 8'(((hi & 15) * 16) + (lo & 15));
    end
  endtask

  task automatic do_op(input logic [2:0] code, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic use_c, input logic cin, input logic cmp,
                       input logic [3:0] mask, input bit plo);
    logic [7:0] er, eb;
    logic       ec, ev, ci;
    bit         dec;
    int         lat;
    ci  = use_c ? exp_p[0] : cin;
    dec = 1'b0;
`ifdef ALU_STAGE_DECIMAL_EN
    dec = exp_p[3] && (code == 3'b000) && !cmp;
`endif
    model(int'(code), int'(a), int'(b), int'(sub), int'(ci), dec, er, eb, ec, ev);
    check_eq("idle_ready", op_ready, 1);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b; op_sub = sub;
    op_use_carry = use_c; op_cin = cin; op_cmp = cmp; op_flag_mask = mask;
    @(posedge clk); @(negedge clk);
    lat = 1;
    while (!res_valid && lat < 8) begin
      check_eq("busy_ready", op_ready, 0);
      op_valid = 1'b1; op_a = 8'($urandom);
      @(negedge clk); lat++;
    end
    op_valid = 1'b0;
    check_eq("latency", lat, dec ? 3 : 2);
    if (plo) begin p_load = 1'b1; p_din = 8'h00; end
    @(negedge clk);
    p_load = 1'b0;
    check_eq("res_pulse", res_valid, 0);
    if (!cmp) exp_res = er;
    if (plo) exp_p = 8'h20;
    else begin
      if (mask[3]) exp_p[7] = eb[7];
      if (mask[2]) exp_p[1] = (eb == 8'h00);
      if (mask[1]) exp_p[0] = ec;
      if (mask[0]) exp_p[6] = ev;
    end
    check_eq("res_data", res_data, exp_res);
    check_eq("p_reg", p_reg, exp_p);
  endtask

  task automatic load_p(input logic [7:0] v);
    p_load = 1'b1; p_din = v;
    @(negedge clk);
    p_load = 1'b0;
    exp_p = v | 8'h20;
    check_eq("p_load_idle", p_reg, exp_p);
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op_code = 3'b000; op_a = 8'h00; op_b = 8'h00;
    op_sub = 1'b0; op_use_carry = 1'b0; op_cin = 1'b0; op_cmp = 1'b0;
    op_flag_mask = 4'h0; p_load = 1'b0; p_din = 8'h00;
    exp_p = 8'h24; exp_res = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", op_ready, 1);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_data", res_data, 8'h00);
    check_eq("rst_p", p_reg, 8'h24);
    check_eq("rst_ctl", alu_control, 3'b000);
    check_eq("rst_ai", alu_AI, 8'h00);
    resetn = 1'b1;
    @(negedge clk);

    do_op(3'b000, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    check_eq("add_p", p_reg, 8'hE4);
    do_op(3'b000, 8'h10, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0);
    check_eq("cmp_keep", res_data, 8'hA0);
    do_op(3'b001, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0);
    check_eq("ror_res", res_data, 8'h80);
    do_op(3'b001, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    check_eq("lsr_z", p_reg[1], 1'b1);
    do_op(3'b000, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1);
    check_eq("pload_win", p_reg, 8'h20);

    load_p(8'h08);
    do_op(3'b000, 8'h15, 8'h27, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    do_op(3'b000, 8'h99, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    do_op(3'b000, 8'h42, 8'h15, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0);
    load_p(8'hC3);

    // Reset while the operation is in EXEC
    op_valid = 1'b1; op_code = 3'b011; op_a = 8'h5A; op_b = 8'h0F; op_flag_mask = 4'hF;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_ready", op_ready, 1);
    check_eq("mid_rst_valid", res_valid, 0);
    check_eq("mid_rst_p", p_reg, 8'h24);
    check_eq("mid_rst_data", res_data, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    exp_p = 8'h24; exp_res = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_valid_after_rst", res_valid, 0);
    end
    do_op(3'b100, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] c;
      c = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) load_p(8'($urandom) & 8'hF7);
      do_op(c, 8'($urandom), 8'($urandom), (c == 3'b000) ? 1'($urandom) : 1'b0,
            1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
